// File: rtl/avalon_mem_bridge.sv
// avalon_mem_bridge: CPU load/store unit to Avalon-MM slave bridge.
// Takes one byte/half/word request at a time and issues a single word-aligned Avalon
// read or write with lane byteenables. Read data is lane-extracted and sign/zero extended.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses
// (no bus cycle, resp_err=1). Without it, the low address bits are masked and resp_err is 0.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready            CPU request handshake (accept on valid&&ready at posedge)
//   req_write/size/signed/addr/wdata  request attributes
//   resp_valid/resp_rdata/resp_err one-cycle completion pulse with load data / error flag
//   avm_*                          Avalon-MM master command and read data
// Latency: store resp one cycle after the acceptance edge, load resp after
// READ_CAPTURE_DELAY more edges; waitrequest stalls extend both without limit.
module avalon_mem_bridge #(
   parameter int ADDR_W             = 32,
   parameter int READ_CAPTURE_DELAY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata
);

   typedef enum logic [2:0] {IDLE, RD, CAPT, WR, RESP} state_t;

   localparam logic [1:0] CAPT_LAST = 2'(READ_CAPTURE_DELAY - 1);

   state_t state, state_d;
   logic [1:0] cnt, cnt_d;
   logic [1:0] lane, lane_d;
   logic [1:0] size, size_d;
   logic       sign, sign_d;

   logic              req_ready_d, resp_valid_d, resp_err_d;
   logic [31:0]       resp_rdata_d, avm_writedata_d;
   logic [ADDR_W-1:0] avm_address_d;
   logic              avm_read_d, avm_write_d;
   logic [3:0]        avm_byteenable_d;

   // Request decode: size 11 behaves as a word; lane index ignores bits masked by size.
   logic [1:0]  req_size_n;
   logic [1:0]  req_lane;
   logic [3:0]  req_be;
   logic [31:0] req_wd;
   logic        misalign;

   assign req_size_n = (req_size == 2'b11) ? 2'b10 : req_size;

   always_comb begin
      req_lane = 2'b00;
      req_be   = 4'b1111;
      req_wd   = req_wdata;
      case (req_size_n)
         2'b00: begin
            req_lane = req_addr[1:0];
            req_be   = 4'b0001 << req_addr[1:0];
            req_wd   = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            req_lane = {req_addr[1], 1'b0};
            req_be   = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wd   = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign misalign = ((req_size_n == 2'b01) && req_addr[0]) ||
                     ((req_size_n == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Read lane extraction from the captured word.
   logic [31:0] rd_shift;
   logic [31:0] rd_ext;

   assign rd_shift = avm_readdata >> {lane, 3'b000};

   always_comb begin
      rd_ext = rd_shift;
      case (size)
         2'b00:   rd_ext = {{24{sign & rd_shift[7]}},  rd_shift[7:0]};
         2'b01:   rd_ext = {{16{sign & rd_shift[15]}}, rd_shift[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= 2'd0;
         lane           <= 2'd0;
         size           <= 2'd0;
         sign           <= 1'b0;
         req_ready      <= 1'b1;
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'd0;
         resp_err       <= 1'b0;
         avm_address    <= '0;
         avm_read       <= 1'b0;
         avm_write      <= 1'b0;
         avm_writedata  <= 32'd0;
         avm_byteenable <= 4'd0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         lane           <= lane_d;
         size           <= size_d;
         sign           <= sign_d;
         req_ready      <= req_ready_d;
         resp_valid     <= resp_valid_d;
         resp_rdata     <= resp_rdata_d;
         resp_err       <= resp_err_d;
         avm_address    <= avm_address_d;
         avm_read       <= avm_read_d;
         avm_write      <= avm_write_d;
         avm_writedata  <= avm_writedata_d;
         avm_byteenable <= avm_byteenable_d;
      end
   end

   // Next-state and next-output logic; outputs are registered one edge later.
   always_comb begin
      state_d          = state;
      cnt_d            = cnt;
      lane_d           = lane;
      size_d           = size;
      sign_d           = sign;
      req_ready_d      = req_ready;
      resp_valid_d     = 1'b0;
      resp_rdata_d     = resp_rdata;
      resp_err_d       = resp_err;
      avm_address_d    = avm_address;
      avm_read_d       = avm_read;
      avm_write_d      = avm_write;
      avm_writedata_d  = avm_writedata;
      avm_byteenable_d = avm_byteenable;

      case (state)
         IDLE: begin
            req_ready_d = 1'b1;
            if (req_valid && req_ready) begin
               req_ready_d = 1'b0;
               lane_d      = req_lane;
               size_d      = req_size_n;
               sign_d      = req_signed;
               if (misalign) begin
                  // Trapped access: straight to the response, no bus cycle.
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else begin
                  avm_address_d    = {req_addr[ADDR_W-1:2], 2'b00};
                  avm_byteenable_d = req_be;
                  avm_writedata_d  = req_wd;
                  avm_read_d       = ~req_write;
                  avm_write_d      = req_write;
                  state_d          = req_write ? WR : RD;
               end
            end
         end
         RD: begin
            if (!avm_waitrequest) begin
               avm_read_d = 1'b0;
               cnt_d      = 2'd0;
               state_d    = CAPT;
            end
         end
         CAPT: begin
            // The slave presents readdata after accepting, so sampling is deferred.
            if (cnt == CAPT_LAST) begin
               resp_rdata_d = rd_ext;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end else begin
               cnt_d = cnt + 2'd1;
            end
         end
         WR: begin
            if (!avm_waitrequest) begin
               avm_write_d  = 1'b0;
               resp_rdata_d = 32'd0;
               resp_err_d   = 1'b0;
               resp_valid_d = 1'b1;
               state_d      = RESP;
            end
         end
         RESP: begin
            req_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_avalon_mem_bridge.sv
// Directed bench for avalon_mem_bridge with a byte-addressed 8x8192 Avalon RAM model
// whose waitrequest stall length is set per request. Expected responses are queued
// when a request is driven and compared when resp_valid appears.
module tb_avalon_mem_bridge;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest;
   logic [3:0]  avm_byteenable;

   always #5 clk = ~clk;

   avalon_mem_bridge #(.ADDR_W(32), .READ_CAPTURE_DELAY(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .avm_address(avm_address), .avm_read(avm_read),
      .avm_write(avm_write), .avm_writedata(avm_writedata),
      .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata)
   );

   // Slave model: stalls stall_cfg cycles per command, readdata updated on acceptance.
   logic [7:0]  mem [0:8191];
   int          stall_cfg;
   int          stall_cnt;
   logic [12:0] idx;

   assign idx             = avm_address[12:0];
   assign avm_waitrequest = (avm_read || avm_write) && (stall_cnt < stall_cfg);

   always @(posedge clk) begin
      if (avm_read || avm_write) stall_cnt <= stall_cnt + 1;
      else                       stall_cnt <= 0;
      if (avm_write && !avm_waitrequest) begin
         for (int i = 0; i < 4; i++)
            if (avm_byteenable[i]) mem[idx + 13'(i)] <= avm_writedata[8*i +: 8];
      end
      if (avm_read && !avm_waitrequest)
         avm_readdata <= {mem[idx + 13'd3], mem[idx + 13'd2], mem[idx + 13'd1], mem[idx]};
   end

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, follow it to its response and check bus and response behaviour.
   task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                         input int stall, input logic [31:0] exp_rdata, input logic exp_err,
                         input logic exp_bus, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input int exp_lat);
      exp_t        e;
      int          k, cmd_cyc, unstable, busy_bad, both;
      logic        got;
      logic [31:0] a0, w0;
      logic [3:0]  b0;
      k = 0; cmd_cyc = 0; unstable = 0; busy_bad = 0; both = 0; got = 1'b0;
      a0 = '0; w0 = '0; b0 = '0;
      stall_cfg = stall;
      @(negedge clk);
      check({tag, "/ready_before"}, 32'(req_ready), 32'd1);
      req_write = wr; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
      req_valid = 1'b1;
      e.rdata = exp_rdata; e.err = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1 req_valid = 1'b0;
      while (!got && k < 100) begin
         @(negedge clk);
         if (avm_read && avm_write) both++;
         if (req_ready) busy_bad++;
         if (avm_read || avm_write) begin
            if (cmd_cyc == 0) begin
               a0 = avm_address; b0 = avm_byteenable; w0 = avm_writedata;
            end else if (avm_address !== a0 || avm_byteenable !== b0 || avm_writedata !== w0) begin
               unstable++;
            end
            cmd_cyc++;
         end
         if (resp_valid) begin
            got = 1'b1;
            if (sb_q.size() == 0) begin
               check({tag, "/sb_nonempty"}, 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               check({tag, "/rdata"}, resp_rdata, e.rdata);
               check({tag, "/err"}, 32'(resp_err), 32'(e.err));
            end
         end else begin
            @(posedge clk);
            k++;
         end
      end
      check({tag, "/resp_seen"}, 32'(got), 32'd1);
      check({tag, "/latency"}, 32'(k), 32'(exp_lat));
      check({tag, "/cmd_cycles"}, 32'(cmd_cyc), exp_bus ? 32'(stall + 1) : 32'd0);
      check({tag, "/cmd_stable"}, 32'(unstable), 32'd0);
      check({tag, "/rd_wr_excl"}, 32'(both), 32'd0);
      check({tag, "/ready_low_busy"}, 32'(busy_bad), 32'd0);
      if (exp_bus) begin
         check({tag, "/addr"}, a0, exp_addr);
         check({tag, "/be"}, 32'(b0), 32'(exp_be));
         if (wr) check({tag, "/wdata"}, w0, exp_wd);
      end
      @(negedge clk);
      check({tag, "/single_pulse"}, 32'(resp_valid), 32'd0);
      check({tag, "/ready_after"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int stray;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; stall_cfg = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst/req_ready", 32'(req_ready), 32'd1);
      check("rst/resp_valid", 32'(resp_valid), 32'd0);
      check("rst/resp_rdata", resp_rdata, 32'd0);
      check("rst/resp_err", 32'(resp_err), 32'd0);
      check("rst/avm_read", 32'(avm_read), 32'd0);
      check("rst/avm_write", 32'(avm_write), 32'd0);
      check("rst/avm_address", avm_address, 32'd0);
      check("rst/avm_writedata", avm_writedata, 32'd0);
      check("rst/avm_byteenable", 32'(avm_byteenable), 32'd0);
      rst_n = 1'b1;

      //     tag        wr  sz    sg  addr        wdata         stall rdata         err bus addr        be       wdata         lat
      do_req("sw100",  1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0,        0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 1);
      do_req("lw100",  0, 2'b10, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 0, 1, 32'h100, 4'b1111, 32'h0,        2);
      do_req("sb103",  1, 2'b00, 0, 32'h103, 32'h000000A5, 0, 32'h0,        0, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 1);
      do_req("lb103",  0, 2'b00, 1, 32'h103, 32'h0,        0, 32'hFFFFFFA5, 0, 1, 32'h100, 4'b1000, 32'h0,        2);
      do_req("lbu103", 0, 2'b00, 0, 32'h103, 32'h0,        0, 32'h000000A5, 0, 1, 32'h100, 4'b1000, 32'h0,        2);
      do_req("sh202",  1, 2'b01, 0, 32'h202, 32'h00008001, 0, 32'h0,        0, 1, 32'h200, 4'b1100, 32'h80018001, 1);
      do_req("lh202",  0, 2'b01, 1, 32'h202, 32'h0,        0, 32'hFFFF8001, 0, 1, 32'h200, 4'b1100, 32'h0,        2);
      do_req("lhu202", 0, 2'b01, 0, 32'h202, 32'h0,        0, 32'h00008001, 0, 1, 32'h200, 4'b1100, 32'h0,        2);
      do_req("sw300s3",1, 2'b11, 0, 32'h300, 32'h12345678, 0, 32'h0,        0, 1, 32'h300, 4'b1111, 32'h12345678, 1);
      do_req("sb301",  1, 2'b00, 0, 32'h301, 32'h0000007F, 0, 32'h0,        0, 1, 32'h300, 4'b0010, 32'h7F7F7F7F, 1);
      do_req("lb301",  0, 2'b00, 1, 32'h301, 32'h0,        0, 32'h0000007F, 0, 1, 32'h300, 4'b0010, 32'h0,        2);
      do_req("lw300",  0, 2'b10, 0, 32'h300, 32'h0,        0, 32'h12347F78, 0, 1, 32'h300, 4'b1111, 32'h0,        2);
      do_req("lw_stl5",0, 2'b10, 0, 32'h100, 32'h0,        5, 32'hA5ADBEEF, 0, 1, 32'h100, 4'b1111, 32'h0,        7);
      do_req("sw_stl3",1, 2'b10, 0, 32'h204, 32'h0BADF00D, 3, 32'h0,        0, 1, 32'h204, 4'b1111, 32'h0BADF00D, 4);
      do_req("lw204",  0, 2'b10, 0, 32'h204, 32'h0,        0, 32'h0BADF00D, 0, 1, 32'h204, 4'b1111, 32'h0,        2);

      // Reset during a stalled read: command dropped, no response.
      stall_cfg = 20;
      @(negedge clk);
      req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h100;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort/in_rd", 32'(avm_read), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort/avm_read", 32'(avm_read), 32'd0);
      check("abort/req_ready", 32'(req_ready), 32'd1);
      check("abort/resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      stall_cfg = 0;
      stray = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid || avm_read) stray++;
      end
      check("abort/no_resp", 32'(stray), 32'd0);
      do_req("post_rst",0, 2'b01, 0, 32'h202, 32'h0,       0, 32'h00008001, 0, 1, 32'h200, 4'b1100, 32'h0,        2);

`ifdef MISALIGN_TRAP_EN
      do_req("lh101",  0, 2'b01, 1, 32'h101, 32'h0,        0, 32'h0,        1, 0, 32'h0,   4'b0000, 32'h0,        0);
`else
      do_req("lh101",  0, 2'b01, 1, 32'h101, 32'h0,        0, 32'hFFFFBEEF, 0, 1, 32'h100, 4'b0011, 32'h0,        2);
`endif

      check("sb/drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
